// File: rtl/keypad_pkg.sv
// Shared constants for the 4x4 keypad entry block: widths, key codes, FSM states,
// and helpers for the key map, row priority and column drive.
package keypad_pkg;

  localparam int unsigned ROWS    = 4;
  localparam int unsigned COLS    = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned VALUE_W = 7;
  localparam int unsigned COUNT_W = 2;

  localparam logic [CODE_W-1:0] KEY_A    = CODE_W'(10);
  localparam logic [CODE_W-1:0] KEY_B    = CODE_W'(11);
  localparam logic [CODE_W-1:0] KEY_C    = CODE_W'(12);
  localparam logic [CODE_W-1:0] KEY_D    = CODE_W'(13);
  localparam logic [CODE_W-1:0] KEY_STAR = CODE_W'(14);
  localparam logic [CODE_W-1:0] KEY_HASH = CODE_W'(15);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Physical layout: rows {1,2,3,A},{4,5,6,B},{7,8,9,C},{*,0,#,D}.
  function automatic logic [CODE_W-1:0] key_map(input logic [IDX_W-1:0] r,
                                                input logic [IDX_W-1:0] c);
    logic [CODE_W-1:0] code;
    case ({r, c})
      4'h0:    code = CODE_W'(1);
      4'h1:    code = CODE_W'(2);
      4'h2:    code = CODE_W'(3);
      4'h3:    code = KEY_A;
      4'h4:    code = CODE_W'(4);
      4'h5:    code = CODE_W'(5);
      4'h6:    code = CODE_W'(6);
      4'h7:    code = KEY_B;
      4'h8:    code = CODE_W'(7);
      4'h9:    code = CODE_W'(8);
      4'hA:    code = CODE_W'(9);
      4'hB:    code = KEY_C;
      4'hC:    code = KEY_STAR;
      4'hD:    code = CODE_W'(0);
      4'hE:    code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  // Lowest-index active-low row wins when several are pressed.
  function automatic logic [IDX_W-1:0] lowest_low(input logic [ROWS-1:0] r);
    logic [IDX_W-1:0] idx;
    if (!r[0])      idx = IDX_W'(0);
    else if (!r[1]) idx = IDX_W'(1);
    else if (!r[2]) idx = IDX_W'(2);
    else            idx = IDX_W'(3);
    return idx;
  endfunction

  function automatic logic [COLS-1:0] col_drive(input logic [IDX_W-1:0] c);
    logic [COLS-1:0] one;
    one = COLS'(1);
    return ~(one << c);
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running divider producing a one-cycle tick every SCAN_DIV clocks.
module scan_tick #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_W'(SCAN_DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounce and a two-digit decimal entry buffer
// committed by '#', cleared by '*'.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ROWS-1:0]    row,
  output logic [COLS-1:0]    col,
  output logic [CODE_W-1:0]  key_code,
  output logic               key_valid,
  output logic [VALUE_W-1:0] value,
  output logic               value_valid,
  output logic [COUNT_W-1:0] digit_count
);

  localparam int unsigned DEB_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

  logic [ROWS-1:0]   row_meta;
  logic [ROWS-1:0]   row_sync;
  logic              tick;
  state_t            state;
  logic [IDX_W-1:0]  col_idx;
  logic [IDX_W-1:0]  row_idx;
  logic [DEB_W-1:0]  deb_cnt;
  logic [3:0]        tens;
  logic [3:0]        units;

  logic              all_high_c;
  logic              deb_done_c;
  logic [IDX_W-1:0]  next_col_c;
  logic [CODE_W-1:0] code_c;

  assign all_high_c = &row_sync;
  assign deb_done_c = (deb_cnt == DEB_W'(DEBOUNCE_SCANS - 1));
  assign next_col_c = col_idx + IDX_W'(1);
  assign code_c     = key_map(row_idx, col_idx);

  // Two-flop synchronizer; idle rows read high.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCAN;
      col_idx     <= '0;
      col         <= col_drive(IDX_W'(0));
      row_idx     <= '0;
      deb_cnt     <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      value       <= '0;
      value_valid <= 1'b0;
      digit_count <= '0;
      tens        <= '0;
      units       <= '0;
    end else begin
      key_valid   <= 1'b0;
      value_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (all_high_c) begin
              col_idx <= next_col_c;
              col     <= col_drive(next_col_c);
            end else begin
              row_idx <= lowest_low(row_sync);
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (!row_sync[row_idx]) begin
              if (deb_done_c) begin
                deb_cnt   <= '0;
                state     <= PRESSED;
                key_code  <= code_c;
                key_valid <= 1'b1;
                // Buffer action happens once, on acceptance.
                if (code_c < CODE_W'(10)) begin
                  tens  <= units;
                  units <= code_c;
                  if (digit_count != COUNT_W'(2)) digit_count <= digit_count + COUNT_W'(1);
                end else if (code_c == KEY_STAR) begin
                  tens        <= '0;
                  units       <= '0;
                  digit_count <= '0;
                end else if (code_c == KEY_HASH) begin
                  value       <= VALUE_W'(tens) * VALUE_W'(10) + VALUE_W'(units);
                  value_valid <= 1'b1;
                  tens        <= '0;
                  units       <= '0;
                  digit_count <= '0;
                end
              end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
              end
            end else begin
              state   <= SCAN;
              col_idx <= next_col_c;
              col     <= col_drive(next_col_c);
            end
          end
          PRESSED, RELEASE: begin
            if (all_high_c) begin
              if (deb_done_c) begin
                deb_cnt <= '0;
                state   <= SCAN;
              end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
                state   <= RELEASE;
              end
            end else begin
              deb_cnt <= '0;
              state   <= PRESSED;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule
